// File: rtl/mem_port_arbiter_if.sv
// Memory-side request/response bus shared by the fetch unit, the LSU and memory.
// A master holds its command stable until it sees waitrequest low; read data
// comes back later, one beat per valid.
interface port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] dataena;
  logic [1:0]          burstcount;
  logic                waitrequest;
  logic                valid;
  logic [DATA_W-1:0]   rdata;

  // Seen from the side that receives commands
  modport slave (
    input  addr, wdata, read, write, dataena, burstcount,
    output waitrequest, valid, rdata
  );

  // Seen from the side that issues commands
  modport master (
    output addr, wdata, read, write, dataena, burstcount,
    input  waitrequest, valid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single memory port.
// M0 = instruction fetch, M1 = load/store unit. One transaction owns the port
// from command acceptance until its last write beat is accepted or its last
// read beat has returned; arbitration only happens in IDLE.
module mem_port_arbiter #(
  parameter int PRIO_MODE = 0  // 0 = round-robin, 1 = fixed priority, M1 wins
) (
  input  logic       clk,
  input  logic       rst,
  port.slave         m0,
  port.slave         m1,
  port.master        s,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;      // one-hot owner {m1,m0}
  logic [1:0] beats_q, beats_d;  // beats still to transfer
  logic       last_q, last_d;    // 1 = M1 was granted last

  logic       req0, req1, win1;
  logic       sel_read, sel_write, wr_fwd;
  logic [1:0] sel_bc, blen;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Round-robin gives the contested round to whoever did not win last time
  assign win1 = (PRIO_MODE == 1) ? req1 : (req1 & (~req0 | ~last_q));

  assign sel_read  = gnt_q[1] ? m1.read       : m0.read;
  assign sel_write = gnt_q[1] ? m1.write      : m0.write;
  assign sel_bc    = gnt_q[1] ? m1.burstcount : m0.burstcount;
  // A read+write command is treated as a read; the write strobe is suppressed
  assign wr_fwd    = sel_write & ~sel_read;
  // burstcount of 0 means a single beat
  assign blen      = (sel_bc == 2'd0) ? 2'd1 : sel_bc;

  assign busy  = (state_q != IDLE);
  assign grant = (state_q != IDLE) ? gnt_q : 2'b00;

  // Next-state logic and port multiplexing
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    beats_d = beats_q;
    last_d  = last_q;

    s.read       = 1'b0;
    s.write      = 1'b0;
    s.addr       = '0;
    s.wdata      = '0;
    s.dataena    = '0;
    s.burstcount = 2'd0;

    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    m0.valid       = 1'b0;
    m1.valid       = 1'b0;
    m0.rdata       = s.rdata;
    m1.rdata       = s.rdata;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          state_d = CMD;
        end
      end

      CMD, WDATA: begin
        s.read  = sel_read;
        s.write = wr_fwd;
        if (gnt_q[1]) begin
          s.addr         = m1.addr;
          s.wdata        = m1.wdata;
          s.dataena      = m1.dataena;
          s.burstcount   = m1.burstcount;
          m1.waitrequest = s.waitrequest;
        end else begin
          s.addr         = m0.addr;
          s.wdata        = m0.wdata;
          s.dataena      = m0.dataena;
          s.burstcount   = m0.burstcount;
          m0.waitrequest = s.waitrequest;
        end

        if (!sel_read && !sel_write) begin
          // Owner withdrew its request; nothing left to forward
          state_d = IDLE;
        end else if (state_q == CMD) begin
          if (!s.waitrequest) begin
            if (sel_read) begin
              beats_d = blen;
              state_d = RDATA;
            end else begin
              beats_d = blen - 2'd1;
              state_d = (blen == 2'd1) ? IDLE : WDATA;
            end
          end
        end else if (wr_fwd && !s.waitrequest) begin
          beats_d = beats_q - 2'd1;
          if (beats_q == 2'd1) state_d = IDLE;
        end
      end

      RDATA: begin
        if (gnt_q[1]) m1.valid = s.valid;
        else          m0.valid = s.valid;
        if (s.valid) begin
          beats_d = beats_q - 2'd1;
          if (beats_q == 2'd1) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves M1 as last owner so M0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      beats_q <= 2'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      beats_q <= beats_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin instance (dut_rr) and a fixed-priority
// instance (dut_fp) driven cycle by cycle with hand-computed expectations.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  port a_m0 ();
  port a_m1 ();
  port a_s ();
  port b_m0 ();
  port b_m1 ();
  port b_s ();

  logic [1:0] a_grant, b_grant;
  logic       a_busy, b_busy;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .m0(a_m0), .m1(a_m1), .s(a_s),
    .grant(a_grant), .busy(a_busy)
  );

  mem_port_arbiter #(.PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .m0(b_m0), .m1(b_m1), .s(b_s),
    .grant(b_grant), .busy(b_busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_m0.read = 0; a_m0.write = 0; a_m0.addr = 0; a_m0.wdata = 0; a_m0.dataena = 0; a_m0.burstcount = 0;
    a_m1.read = 0; a_m1.write = 0; a_m1.addr = 0; a_m1.wdata = 0; a_m1.dataena = 0; a_m1.burstcount = 0;
    b_m0.read = 0; b_m0.write = 0; b_m0.addr = 0; b_m0.wdata = 0; b_m0.dataena = 0; b_m0.burstcount = 0;
    b_m1.read = 0; b_m1.write = 0; b_m1.addr = 0; b_m1.wdata = 0; b_m1.dataena = 0; b_m1.burstcount = 0;
    a_s.waitrequest = 1; a_s.valid = 0; a_s.rdata = 0;
    b_s.waitrequest = 1; b_s.valid = 0; b_s.rdata = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    step;
    step;
    rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst = 1;
    a_m0.read = 1;  // request during reset must not start anything
    step;
    step;
    #1;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy_held: busy=%b want 0", a_busy); end
    a_m0.read = 0;
    rst = 0;
    step;
    #1;
    total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL rst_grant: grant=%b want 00", a_grant); end
    total++; if (a_s.read !== 1'b0 || a_s.write !== 1'b0) begin bad++; $display("FAIL rst_cmd: rd=%b wr=%b want 0 0", a_s.read, a_s.write); end
    total++; if (a_m0.waitrequest !== 1'b1 || a_m1.waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait: w0=%b w1=%b want 1 1", a_m0.waitrequest, a_m1.waitrequest); end
    total++; if (b_busy !== 1'b0 || b_grant !== 2'b00) begin bad++; $display("FAIL rst_fp: busy=%b grant=%b want 0 00", b_busy, b_grant); end
  endtask

  task automatic test_single_read;
    a_m0.read = 1; a_m0.addr = 32'h100; a_m0.burstcount = 1;
    a_s.waitrequest = 0;
    #1;
    total++; if (a_s.read !== 1'b0 || a_grant !== 2'b00) begin bad++; $display("FAIL sr_idle: rd=%b grant=%b want 0 00", a_s.read, a_grant); end
    step;
    #1;
    total++; if (a_s.read !== 1'b1 || a_s.addr !== 32'h100) begin bad++; $display("FAIL sr_cmd: rd=%b addr=%h want 1 100", a_s.read, a_s.addr); end
    total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL sr_grant: grant=%b want 01", a_grant); end
    total++; if (a_m0.waitrequest !== 1'b0 || a_m1.waitrequest !== 1'b1) begin bad++; $display("FAIL sr_wait: w0=%b w1=%b want 0 1", a_m0.waitrequest, a_m1.waitrequest); end
    step;
    a_m0.read = 0; a_m0.addr = 0;
    #1;
    total++; if (a_s.read !== 1'b0 || a_busy !== 1'b1 || a_m0.valid !== 1'b0) begin bad++; $display("FAIL sr_wait_data: rd=%b busy=%b v0=%b want 0 1 0", a_s.read, a_busy, a_m0.valid); end
    step;
    a_s.valid = 1; a_s.rdata = 32'hDEADBEEF;
    #1;
    total++; if (a_m0.valid !== 1'b1 || a_m0.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_data: v0=%b rdata=%h want 1 deadbeef", a_m0.valid, a_m0.rdata); end
    total++; if (a_m1.valid !== 1'b0 || a_grant !== 2'b01) begin bad++; $display("FAIL sr_data_other: v1=%b grant=%b want 0 01", a_m1.valid, a_grant); end
    step;
    a_s.valid = 0;
    #1;
    total++; if (a_grant !== 2'b00 || a_busy !== 1'b0) begin bad++; $display("FAIL sr_done: grant=%b busy=%b want 00 0", a_grant, a_busy); end
  endtask

  task automatic test_rr_contention;
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    logic        loser_wait, win_v, lose_v;
    do_reset;
    a_m0.read = 1; a_m0.addr = 32'h200; a_m0.burstcount = 1;
    a_m1.read = 1; a_m1.addr = 32'h300; a_m1.burstcount = 0;  // 0 counts as one beat
    a_s.waitrequest = 0;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
      exp_a = (t % 2 == 1) ? 32'h300 : 32'h200;
      #1;
      total++; if (a_grant !== 2'b00 || a_m0.waitrequest !== 1'b1 || a_m1.waitrequest !== 1'b1) begin bad++; $display("FAIL rr_idle[%0d]: grant=%b w0=%b w1=%b want 00 1 1", t, a_grant, a_m0.waitrequest, a_m1.waitrequest); end
      step;
      #1;
      loser_wait = exp_g[0] ? a_m1.waitrequest : a_m0.waitrequest;
      total++; if (a_grant !== exp_g || a_s.addr !== exp_a) begin bad++; $display("FAIL rr_grant[%0d]: grant=%b addr=%h want %b %h", t, a_grant, a_s.addr, exp_g, exp_a); end
      total++; if (loser_wait !== 1'b1) begin bad++; $display("FAIL rr_loser_wait[%0d]: wait=%b want 1", t, loser_wait); end
      step;
      a_s.valid = 1; a_s.rdata = t;
      #1;
      win_v  = exp_g[0] ? a_m0.valid : a_m1.valid;
      lose_v = exp_g[0] ? a_m1.valid : a_m0.valid;
      loser_wait = exp_g[0] ? a_m1.waitrequest : a_m0.waitrequest;
      total++; if (win_v !== 1'b1 || lose_v !== 1'b0 || loser_wait !== 1'b1) begin bad++; $display("FAIL rr_data[%0d]: win_v=%b lose_v=%b lose_wait=%b want 1 0 1", t, win_v, lose_v, loser_wait); end
      step;
      a_s.valid = 0;
    end
    a_m0.read = 0; a_m0.addr = 0;
    a_m1.read = 0; a_m1.addr = 0;
  endtask

  task automatic test_prio_writes;
    logic [31:0] wv [3];
    wv[0] = 32'h1111_0000; wv[1] = 32'h2222_0001; wv[2] = 32'h3333_0002;
    b_m0.read = 1; b_m0.addr = 32'h400; b_m0.burstcount = 1;
    b_m1.write = 1; b_m1.addr = 32'h10; b_m1.burstcount = 1; b_m1.dataena = 4'hF; b_m1.wdata = wv[0];
    b_s.waitrequest = 0;
    for (int w = 0; w < 3; w++) begin
      #1;
      total++; if (b_grant !== 2'b00) begin bad++; $display("FAIL fp_idle[%0d]: grant=%b want 00", w, b_grant); end
      step;
      #1;
      total++; if (b_grant !== 2'b10 || b_s.write !== 1'b1 || b_s.wdata !== wv[w]) begin bad++; $display("FAIL fp_write[%0d]: grant=%b wr=%b wdata=%h want 10 1 %h", w, b_grant, b_s.write, b_s.wdata, wv[w]); end
      total++; if (b_m0.waitrequest !== 1'b1) begin bad++; $display("FAIL fp_m0_wait[%0d]: wait=%b want 1", w, b_m0.waitrequest); end
      step;
      if (w < 2) b_m1.wdata = wv[w+1];
      else b_m1.write = 0;
    end
    #1;
    total++; if (b_grant !== 2'b00) begin bad++; $display("FAIL fp_gap: grant=%b want 00", b_grant); end
    step;
    #1;
    total++; if (b_grant !== 2'b01 || b_s.read !== 1'b1 || b_s.addr !== 32'h400) begin bad++; $display("FAIL fp_m0: grant=%b rd=%b addr=%h want 01 1 400", b_grant, b_s.read, b_s.addr); end
    step;
    b_m0.read = 0;
    b_s.valid = 1; b_s.rdata = 32'h55;
    #1;
    total++; if (b_m0.valid !== 1'b1) begin bad++; $display("FAIL fp_m0_data: v0=%b want 1", b_m0.valid); end
    step;
    b_s.valid = 0;
    #1;
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL fp_done: busy=%b want 0", b_busy); end
  endtask

  task automatic test_write_burst;
    logic [31:0] dv [3];
    logic        pat [5];
    int          d;
    int          acc;
    dv[0] = 32'hA0A0_0000; dv[1] = 32'hB1B1_0001; dv[2] = 32'hC2C2_0002;
    pat[0] = 0; pat[1] = 1; pat[2] = 0; pat[3] = 1; pat[4] = 0;
    d = 0;
    acc = 0;
    a_m1.write = 1; a_m1.addr = 32'h20; a_m1.burstcount = 3; a_m1.dataena = 4'hF; a_m1.wdata = dv[0];
    a_s.waitrequest = 0;
    #1;
    step;
    for (int i = 0; i < 5; i++) begin
      a_s.waitrequest = pat[i];
      a_s.valid = (i == 1);  // stray beat during a write must not leak out
      #1;
      if (a_s.write === 1'b1 && a_s.waitrequest === 1'b0) acc++;
      total++; if (a_s.write !== 1'b1 || a_s.wdata !== dv[d] || a_grant !== 2'b10) begin bad++; $display("FAIL wb_beat[%0d]: wr=%b wdata=%h grant=%b want 1 %h 10", i, a_s.write, a_s.wdata, a_grant, dv[d]); end
      total++; if (a_m1.waitrequest !== pat[i] || a_m1.valid !== 1'b0 || a_m0.valid !== 1'b0) begin bad++; $display("FAIL wb_resp[%0d]: w1=%b v1=%b v0=%b want %b 0 0", i, a_m1.waitrequest, a_m1.valid, a_m0.valid, pat[i]); end
      step;
      a_s.valid = 0;
      if (!pat[i]) begin
        d++;
        if (d < 3) a_m1.wdata = dv[d];
        else begin
          a_m1.write = 0;
          d = 2;
        end
      end
    end
    #1;
    total++; if (acc !== 3) begin bad++; $display("FAIL wb_count: accepted=%0d want 3", acc); end
    total++; if (a_busy !== 1'b0 || a_grant !== 2'b00 || a_s.write !== 1'b0) begin bad++; $display("FAIL wb_done: busy=%b grant=%b wr=%b want 0 00 0", a_busy, a_grant, a_s.write); end
  endtask

  task automatic test_read_burst_stray;
    int pulses;
    pulses = 0;
    a_m0.read = 1; a_m0.addr = 32'h600; a_m0.burstcount = 2;
    a_s.waitrequest = 0;
    #1;
    step;
    #1;
    total++; if (a_s.burstcount !== 2'd2 || a_grant !== 2'b01) begin bad++; $display("FAIL rb_cmd: bc=%0d grant=%b want 2 01", a_s.burstcount, a_grant); end
    step;
    a_m0.read = 0;
    for (int i = 0; i < 3; i++) begin
      a_s.valid = 1; a_s.rdata = 32'hA0 + i;
      #1;
      if (a_m0.valid === 1'b1) pulses++;
      total++; if (a_m1.valid !== 1'b0 || a_busy !== (i < 2)) begin bad++; $display("FAIL rb_beat[%0d]: v1=%b busy=%b want 0 %b", i, a_m1.valid, a_busy, (i < 2)); end
      if (i == 0) begin
        total++; if (a_m0.rdata !== 32'hA0) begin bad++; $display("FAIL rb_rdata: rdata=%h want a0", a_m0.rdata); end
      end
      step;
    end
    a_s.valid = 0;
    total++; if (pulses !== 2) begin bad++; $display("FAIL rb_pulses: m0.valid pulses=%0d want 2", pulses); end
  endtask

  task automatic test_reset_mid_rdata;
    a_m0.read = 1; a_m0.addr = 32'h700; a_m0.burstcount = 2;
    a_s.waitrequest = 0;
    #1;
    step;
    #1;
    step;
    a_m0.read = 0;
    a_s.valid = 1; a_s.rdata = 32'h1;
    #1;
    total++; if (a_m0.valid !== 1'b1) begin bad++; $display("FAIL rm_beat1: v0=%b want 1", a_m0.valid); end
    step;
    a_s.valid = 0;
    rst = 1;
    #1;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rm_pre: busy=%b want 1", a_busy); end
    step;
    rst = 0;
    a_s.valid = 1; a_s.rdata = 32'h2;  // late beat of the aborted read
    #1;
    total++; if (a_grant !== 2'b00 || a_busy !== 1'b0 || a_s.read !== 1'b0) begin bad++; $display("FAIL rm_after: grant=%b busy=%b rd=%b want 00 0 0", a_grant, a_busy, a_s.read); end
    total++; if (a_m0.valid !== 1'b0 || a_m1.valid !== 1'b0) begin bad++; $display("FAIL rm_late: v0=%b v1=%b want 0 0", a_m0.valid, a_m1.valid); end
    step;
    a_s.valid = 0;
    a_m1.read = 1; a_m1.addr = 32'h500; a_m1.burstcount = 1;
    #1;
    total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL rm_idle: grant=%b want 00", a_grant); end
    step;
    #1;
    total++; if (a_grant !== 2'b10 || a_s.read !== 1'b1 || a_s.addr !== 32'h500) begin bad++; $display("FAIL rm_new: grant=%b rd=%b addr=%h want 10 1 500", a_grant, a_s.read, a_s.addr); end
    step;
    a_m1.read = 0;
    a_s.valid = 1; a_s.rdata = 32'h3;
    #1;
    total++; if (a_m1.valid !== 1'b1 || a_m1.rdata !== 32'h3) begin bad++; $display("FAIL rm_new_data: v1=%b rdata=%h want 1 3", a_m1.valid, a_m1.rdata); end
    step;
    a_s.valid = 0;
    #1;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rm_done: busy=%b want 0", a_busy); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_rr_contention;
    test_prio_writes;
    test_write_burst;
    test_read_burst_stray;
    test_reset_mid_rdata;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
